// File: rtl/lcd_text_sequencer_if.sv
// Byte-write handshake between the text sequencer and the LCD byte-write engine.
interface lcd_text_sequencer_if;
  logic       cmd_valid;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_rs, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_rs, input cmd_data, output cmd_ready);
endinterface

// File: rtl/lcd_text_sequencer.sv
// 2-line character buffer plus the pass sequencer that streams clear/address/character
// bytes to the LCD byte-write engine over a valid/ready handshake.
module lcd_text_sequencer #(
  parameter int unsigned CHARS_PER_LINE = 16,
  parameter logic [7:0]  LINE1_ADDR     = 8'h80,
  parameter logic [7:0]  LINE2_ADDR     = 8'hC0,
  parameter logic [7:0]  CLEAR_CMD      = 8'h01,
  parameter logic [7:0]  FILL_CHAR      = 8'h20
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_init_done,
  input  logic                 i_buf_we,
  input  logic [4:0]           i_buf_addr,
  input  logic [7:0]           i_buf_data,
  input  logic                 i_refresh,
  input  logic                 i_clear_first,
  lcd_text_sequencer_if.master io_cmd,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned DEPTH   = 2 * CHARS_PER_LINE;
  localparam logic [4:0]  L1_LAST = 5'(CHARS_PER_LINE - 1);
  localparam logic [4:0]  L2_LAST = 5'(DEPTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_SET_L1 = 3'd2;
  localparam logic [2:0] S_WR_L1  = 3'd3;
  localparam logic [2:0] S_SET_L2 = 3'd4;
  localparam logic [2:0] S_WR_L2  = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  logic [2:0] r_state;
  logic [4:0] r_idx;
  logic       r_pending;
  logic       r_pend_clear;
  logic [7:0] r_buf [DEPTH];
  logic       r_valid;
  logic       r_rs;
  logic [7:0] r_data;
  logic       r_busy;
  logic       r_done;

  logic [2:0] w_state_nx;
  logic [4:0] w_idx_nx;
  logic       w_pending_nx;
  logic       w_pend_clear_nx;
  logic       w_start;
  logic       w_start_clear;
  logic       w_accept;
  logic       w_load;

  assign w_accept = r_valid & io_cmd.cmd_ready;
  // Output registers reload only when nothing is presented or the current byte was taken.
  assign w_load   = ~r_valid | w_accept;

  always_comb begin
    w_state_nx      = r_state;
    w_idx_nx        = r_idx;
    w_pending_nx    = r_pending;
    w_pend_clear_nx = r_pend_clear;
    w_start         = 1'b0;
    w_start_clear   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_refresh && i_init_done) begin
          w_start       = 1'b1;
          w_start_clear = i_clear_first;
        end
      end
      S_FINISH: begin
        // A request arriving in FINISH merges with the pending one and starts back-to-back.
        if (r_pending || i_refresh) begin
          w_start       = 1'b1;
          w_start_clear = r_pend_clear | (i_refresh & i_clear_first);
        end else begin
          w_state_nx = S_IDLE;
        end
        w_pending_nx    = 1'b0;
        w_pend_clear_nx = 1'b0;
      end
      default: begin
        if (i_refresh) begin
          w_pending_nx    = 1'b1;
          w_pend_clear_nx = r_pend_clear | i_clear_first;
        end
        if (w_accept) begin
          case (r_state)
            S_CLEAR:  w_state_nx = S_SET_L1;
            S_SET_L1: w_state_nx = S_WR_L1;
            S_WR_L1: begin
              w_idx_nx = r_idx + 5'd1;
              if (r_idx == L1_LAST) w_state_nx = S_SET_L2;
            end
            S_SET_L2: w_state_nx = S_WR_L2;
            S_WR_L2: begin
              w_idx_nx = r_idx + 5'd1;
              if (r_idx == L2_LAST) w_state_nx = S_FINISH;
            end
            default:  w_state_nx = S_IDLE;
          endcase
        end
      end
    endcase
    if (w_start) begin
      w_state_nx = w_start_clear ? S_CLEAR : S_SET_L1;
      w_idx_nx   = '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_buf[i] <= FILL_CHAR;
    end else if (i_buf_we) begin
      r_buf[i_buf_addr] <= i_buf_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_pending    <= 1'b0;
      r_pend_clear <= 1'b0;
      r_valid      <= 1'b0;
      r_rs         <= 1'b0;
      r_data       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_idx        <= w_idx_nx;
      r_pending    <= w_pending_nx;
      r_pend_clear <= w_pend_clear_nx;
      if (w_load) begin
        r_valid <= (w_state_nx != S_IDLE) && (w_state_nx != S_FINISH);
        r_busy  <= (w_state_nx != S_IDLE) && (w_state_nx != S_FINISH);
        r_done  <= (w_state_nx == S_FINISH);
        r_rs    <= (w_state_nx == S_WR_L1) || (w_state_nx == S_WR_L2);
        case (w_state_nx)
          S_CLEAR:          r_data <= CLEAR_CMD;
          S_SET_L1:         r_data <= LINE1_ADDR;
          S_SET_L2:         r_data <= LINE2_ADDR;
          S_WR_L1, S_WR_L2: r_data <= r_buf[w_idx_nx];
          default:          r_data <= '0;
        endcase
      end
    end
  end

  assign io_cmd.cmd_valid = r_valid;
  assign io_cmd.cmd_rs    = r_rs;
  assign io_cmd.cmd_data  = r_data;
  assign o_busy           = r_busy;
  assign o_done           = r_done;

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Self-checking bench for lcd_text_sequencer: directed vector table, hand sequences for
// pending/reset corners, and a randomized run against a pass-position reference model.
module tb_lcd_text_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, init_done, buf_we, refresh, clear_first;
  logic [4:0] buf_addr;
  logic [7:0] buf_data;
  logic       busy, done;

  lcd_text_sequencer_if cmd_if ();

  lcd_text_sequencer #(
    .CHARS_PER_LINE(16),
    .LINE1_ADDR    (8'h80),
    .LINE2_ADDR    (8'hC0),
    .CLEAR_CMD     (8'h01),
    .FILL_CHAR     (8'h20)
  ) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_init_done  (init_done),
    .i_buf_we     (buf_we),
    .i_buf_addr   (buf_addr),
    .i_buf_data   (buf_data),
    .i_refresh    (refresh),
    .i_clear_first(clear_first),
    .io_cmd       (cmd_if),
    .o_busy       (busy),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [8:0] acc_q[$];

  // Reference model: pass position k into a 34/35-byte stream, plus a mirror of the buffer.
  logic [7:0] mem [32];
  bit         m_busy, m_fin, m_clr, m_pend, m_pclr;
  int         m_k;
  logic       m_rs;
  logic [7:0] m_data;

  typedef struct {
    bit         ready;
    bit         v;
    bit         rs;
    logic [7:0] d;
    bit         busy;
    bit         done;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pass_len(input bit c);
    return c ? 35 : 34;
  endfunction

  task automatic model_byte();
    int k;
    if (m_clr && m_k == 0) begin
      m_rs = 1'b0; m_data = 8'h01;
    end else begin
      k = m_clr ? m_k - 1 : m_k;
      if (k == 0)       begin m_rs = 1'b0; m_data = 8'h80; end
      else if (k <= 16) begin m_rs = 1'b1; m_data = mem[k-1]; end
      else if (k == 17) begin m_rs = 1'b0; m_data = 8'hC0; end
      else              begin m_rs = 1'b1; m_data = mem[k-2]; end
    end
  endtask

  task automatic model_edge(input bit rdy);
    bit start, sc;
    start = 1'b0; sc = 1'b0;
    if (!rst_n) begin
      m_busy = 0; m_fin = 0; m_pend = 0; m_pclr = 0;
      for (int i = 0; i < 32; i++) mem[i] = 8'h20;
      return;
    end
    if (m_fin) begin
      m_fin = 0;
      if (m_pend || refresh) begin start = 1; sc = m_pclr | (refresh & clear_first); end
      m_pend = 0; m_pclr = 0;
    end else if (m_busy) begin
      if (refresh) begin m_pend = 1; m_pclr = m_pclr | clear_first; end
      if (rdy) begin
        m_k++;
        if (m_k == pass_len(m_clr)) begin m_busy = 0; m_fin = 1; end
        else model_byte();
      end
    end else if (refresh && init_done) begin
      start = 1; sc = clear_first;
    end
    if (start) begin m_busy = 1; m_clr = sc; m_k = 0; model_byte(); end
    if (buf_we) mem[buf_addr] = buf_data;
  endtask

  // One clock: inputs already driven; model advanced and outputs compared on the falling edge.
  task automatic step();
    bit rdy;
    rdy = cmd_if.cmd_ready;
    if (rst_n && cmd_if.cmd_valid && rdy) acc_q.push_back({cmd_if.cmd_rs, cmd_if.cmd_data});
    @(posedge clk);
    @(negedge clk);
    model_edge(rdy);
    refresh = 1'b0;
    buf_we  = 1'b0;
    if (done) done_cnt++;
    chk("valid", cmd_if.cmd_valid, m_busy);
    chk("busy", busy, m_busy);
    chk("done", done, m_fin);
    if (m_busy) begin
      chk("rs", cmd_if.cmd_rs, m_rs);
      chk("data", cmd_if.cmd_data, m_data);
    end
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin step(); n++; end
    chk("done_timeout", done, 1'b1);
  endtask

  task automatic write_char(input int a, input logic [7:0] c);
    buf_we = 1'b1; buf_addr = 5'(a); buf_data = c;
    step();
  endtask

  initial begin
    string l1, l2;
    logic [7:0] line [2][16];
    int d0;
    l1 = "HELLO"; l2 = "WORLD";
    for (int i = 0; i < 16; i++) begin
      line[0][i] = (i < 5) ? l1[i] : 8'h20;
      line[1][i] = (i < 5) ? l2[i] : 8'h20;
    end
    for (int b = 0; b < 34; b++) begin
      logic [8:0] e;
      if (b == 0)       e = {1'b0, 8'h80};
      else if (b <= 16) e = {1'b1, line[0][b-1]};
      else if (b == 17) e = {1'b0, 8'hC0};
      else              e = {1'b1, line[1][b-18]};
      if (b == 5) for (int s = 0; s < 5; s++) vecs.push_back('{0, 1, e[8], e[7:0], 1, 0});
      vecs.push_back('{1, 1, e[8], e[7:0], 1, 0});
    end
    vecs.push_back('{1, 0, 0, 8'h00, 0, 1});
    vecs.push_back('{1, 0, 0, 8'h00, 0, 0});

    rst_n = 0; init_done = 0; buf_we = 0; buf_addr = '0; buf_data = '0;
    refresh = 0; clear_first = 0; cmd_if.cmd_ready = 0;
    @(negedge clk);
    step(); step();
    chk("rst_valid", cmd_if.cmd_valid, 0);
    chk("rst_rs", cmd_if.cmd_rs, 0);
    chk("rst_data", cmd_if.cmd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Blank buffer pass
    rst_n = 1; init_done = 1; cmd_if.cmd_ready = 1;
    acc_q.delete();
    refresh = 1; step();
    run_until_done(100);
    chk("blank_len", acc_q.size(), 34);
    for (int i = 0; i < 34 && i < acc_q.size(); i++)
      chk("blank_byte", acc_q[i], (i == 0) ? 9'h080 : (i == 17) ? 9'h0C0 : 9'h120);
    step();

    // HELLO/WORLD table with a 5-cycle stall inside line 1
    for (int i = 0; i < 5; i++) write_char(i, l1[i]);
    for (int i = 0; i < 5; i++) write_char(16 + i, l2[i]);
    d0 = done_cnt;
    refresh = 1; step();
    foreach (vecs[i]) begin
      chk("tbl_valid", cmd_if.cmd_valid, vecs[i].v);
      chk("tbl_busy", busy, vecs[i].busy);
      chk("tbl_done", done, vecs[i].done);
      if (vecs[i].v) begin
        chk("tbl_rs", cmd_if.cmd_rs, vecs[i].rs);
        chk("tbl_data", cmd_if.cmd_data, vecs[i].d);
      end
      cmd_if.cmd_ready = vecs[i].ready;
      step();
    end
    chk("tbl_done_cnt", done_cnt - d0, 1);

    // Clear_First pass
    acc_q.delete();
    refresh = 1; clear_first = 1; step();
    clear_first = 0;
    run_until_done(100);
    chk("clr_len", acc_q.size(), 35);
    if (acc_q.size() >= 3) begin
      chk("clr_b0", acc_q[0], 9'h001);
      chk("clr_b1", acc_q[1], 9'h080);
      chk("clr_b2", acc_q[2], {1'b1, 8'h48});
    end
    step(); step();

    // Two refreshes during a pass merge into exactly one follow-on pass
    acc_q.delete();
    d0 = done_cnt;
    refresh = 1; step();
    step(); step();
    refresh = 1; step();
    step();
    refresh = 1; step();
    run_until_done(100);
    step();
    chk("pend_restart_valid", cmd_if.cmd_valid, 1);
    chk("pend_restart_data", cmd_if.cmd_data, 8'h80);
    run_until_done(100);
    for (int i = 0; i < 4; i++) step();
    chk("pend_done_cnt", done_cnt - d0, 2);
    chk("pend_len", acc_q.size(), 68);
    chk("pend_idle", busy, 0);

    // Refresh ignored before init completes
    init_done = 0;
    refresh = 1; step();
    for (int i = 0; i < 3; i++) step();
    chk("noinit_valid", cmd_if.cmd_valid, 0);

    // Reset mid line 2 aborts immediately
    init_done = 1;
    acc_q.delete();
    refresh = 1; step();
    for (int i = 0; i < 22; i++) step();
    chk("mid_l2_rs", cmd_if.cmd_rs, 1);
    rst_n = 0; step();
    chk("abort_valid", cmd_if.cmd_valid, 0);
    chk("abort_busy", busy, 0);
    rst_n = 1;
    for (int i = 0; i < 3; i++) step();
    chk("abort_stays_idle", cmd_if.cmd_valid, 0);

    // Randomized traffic against the reference model
    for (int c = 0; c < 4000; c++) begin
      cmd_if.cmd_ready = ($urandom_range(0, 3) != 0);
      refresh     = ($urandom_range(0, 24) == 0);
      clear_first = $urandom_range(0, 1);
      buf_we      = ($urandom_range(0, 3) == 0);
      buf_addr    = 5'($urandom_range(0, 31));
      buf_data    = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) init_done = ~init_done;
      rst_n       = ($urandom_range(0, 1499) != 0);
      step();
    end
    rst_n = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
